// File: rtl/dll_tx_seq_tracker.sv
// dll_tx_seq_tracker: registers transmit TLP beats, stamps each TLP with a
// 12-bit sequence number, marks first/last beats and tracks retry-buffer
// space through a FIFO of outstanding TLPs that Ack DLLPs retire.
// Optional build macro: DLL_TX_SEQ_CHECK_EN compiles in the sticky protocol
// checker that drives err_o; without it err_o is tied low.
//
// Handshake: there is no back-pressure. Every cycle carries one beat code on
// req_i; ack_en_i is a one-cycle strobe qualifying ack_seq_i. Outputs follow
// their input beat by exactly one clock.
module dll_tx_seq_tracker #(
  parameter int RETRY_DEPTH_LG2 = 8,
  parameter int OUTST_DEPTH_LG2 = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [255:0]               tlp_i,
  input  logic [2:0]                 req_i,
  input  logic                       ack_en_i,
  input  logic [11:0]                ack_seq_i,
  output logic [255:0]               tlp_o,
  output logic [2:0]                 req_o,
  output logic [11:0]                seq_o,
  output logic                       sof_o,
  output logic                       eof_o,
  output logic [RETRY_DEPTH_LG2+2:0] retry_buffer_leftover_cnt_o,
  output logic                       outst_full_o,
  output logic                       err_o
);
  localparam int CNT_W = RETRY_DEPTH_LG2 + 3;
  localparam int SUM_W = CNT_W + 9;
  localparam int DEPTH = 1 << OUTST_DEPTH_LG2;
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(1) << (RETRY_DEPTH_LG2 + 2);
  localparam logic [SUM_W-1:0] CAP_W = SUM_W'(CAP);

  localparam logic [2:0] REQ_P_HDR    = 3'd1;
  localparam logic [2:0] REQ_P_DATA   = 3'd2;
  localparam logic [2:0] REQ_NP_HDR   = 3'd3;
  localparam logic [2:0] REQ_CPL_HDR  = 3'd5;
  localparam logic [2:0] REQ_CPL_DATA = 3'd6;

  typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic        is_hdr, is_data;
  logic [9:0]  len;
  logic [7:0]  data_beats;
  logic [7:0]  units;
  logic        sof_d, eof_d;
  logic [11:0] next_seq_q;

  logic [11:0]              seq_mem   [DEPTH];
  logic [7:0]               units_mem [DEPTH];
  logic [OUTST_DEPTH_LG2-1:0] rd_ptr, wr_ptr;
  logic [OUTST_DEPTH_LG2:0]   occ;
  logic        ack_v_q;
  logic [11:0] ack_seq_q;
  logic [11:0] head_seq, seq_dist;
  logic [7:0]  head_units;
  logic        push, retire;
  logic [CNT_W-1:0] left_q, left_d;
  logic [SUM_W-1:0] sum, debit;

  // Decode the incoming beat; Length 0 means 1024 DW, i.e. 128 data beats.
  always_comb begin
    is_hdr  = (req_i == REQ_P_HDR) || (req_i == REQ_NP_HDR) || (req_i == REQ_CPL_HDR);
    is_data = (req_i == REQ_P_DATA) || (req_i == REQ_CPL_DATA);
    len     = tlp_i[9:0];
    if (!tlp_i[30])        data_beats = 8'd0;
    else if (len == 10'd0) data_beats = 8'd128;
    else                   data_beats = 8'(({1'b0, len} + 11'd7) >> 3);
    units   = data_beats + 8'd1;
  end

  // FSM state register and remaining-data-beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state: a header always opens a new TLP; data beats count down in DATA,
  // any other code leaves the count untouched.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (is_hdr) begin
      rem_d   = data_beats;
      state_d = (data_beats != 8'd0) ? ST_DATA : ST_IDLE;
    end else if (state_q == ST_DATA && is_data) begin
      rem_d = rem_q - 8'd1;
      if (rem_q == 8'd1) state_d = ST_IDLE;
    end
  end

  // FSM outputs: framing of the beat being registered this cycle.
  always_comb begin
    sof_d = is_hdr;
    eof_d = is_hdr ? (data_beats == 8'd0)
                   : (state_q == ST_DATA && is_data && rem_q == 8'd1);
  end

  // Output beat register and sequence-number allocation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tlp_o      <= '0;
      req_o      <= 3'd0;
      seq_o      <= 12'd0;
      sof_o      <= 1'b0;
      eof_o      <= 1'b0;
      next_seq_q <= 12'd0;
    end else begin
      tlp_o <= tlp_i;
      req_o <= req_i;
      sof_o <= sof_d;
      eof_o <= eof_d;
      if (is_hdr) begin
        seq_o      <= next_seq_q;
        next_seq_q <= next_seq_q + 12'd1;
      end
    end
  end

  assign outst_full_o = (occ == (OUTST_DEPTH_LG2 + 1)'(DEPTH));
  assign head_seq     = seq_mem[rd_ptr];
  assign head_units   = units_mem[rd_ptr];
  assign seq_dist     = ack_seq_q - head_seq;
  assign push         = is_hdr && !outst_full_o;
  // Head is covered by the Ack when it lies at most 2047 behind it (mod 4096).
  assign retire       = ack_v_q && (occ != '0) && !seq_dist[11];

  // Outstanding table storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) begin
      seq_mem[wr_ptr]   <= next_seq_q;
      units_mem[wr_ptr] <= units;
    end
  end

  // Table pointers, occupancy and the latched Ack sequence number.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      ack_v_q   <= 1'b0;
      ack_seq_q <= 12'd0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      if (push && !retire)      occ <= occ + 1'b1;
      else if (!push && retire) occ <= occ - 1'b1;
      if (ack_en_i) begin
        ack_v_q   <= 1'b1;
        ack_seq_q <= ack_seq_i;
      end
    end
  end

  // Net leftover update: credit of the retired head minus debit of the new
  // entry in one step, saturated to the range 0..CAP.
  always_comb begin
    sum   = SUM_W'(left_q) + (retire ? SUM_W'(head_units) : '0);
    debit = push ? SUM_W'(units) : '0;
    if (sum < debit)              left_d = '0;
    else if (sum - debit > CAP_W) left_d = CAP;
    else                          left_d = CNT_W'(sum - debit);
  end

  // Leftover retry-buffer units register.
  always_ff @(posedge clk) begin
    if (!rst_n) left_q <= CAP;
    else        left_q <= left_d;
  end

  assign retry_buffer_leftover_cnt_o = left_q;

`ifdef DLL_TX_SEQ_CHECK_EN
  logic err_q;
  logic proto_err;

  assign proto_err = (is_data && state_q == ST_IDLE) ||
                     (is_hdr && state_q == ST_DATA) ||
                     (is_hdr && outst_full_o) ||
                     (push && (SUM_W'(units) > SUM_W'(left_q)));

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (proto_err) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dll_tx_seq_tracker.sv
// tb_dll_tx_seq_tracker: directed scenarios plus randomized TLP traffic for
// dll_tx_seq_tracker, checked every cycle against a queue-based model of the
// sequence numbering and retry-credit rules.
module tb_dll_tx_seq_tracker;
  localparam int CAP   = 1024;
  localparam int DEPTH = 32;
`ifdef DLL_TX_SEQ_CHECK_EN
  localparam logic EXP_ERR_FULL = 1'b1;
`else
  localparam logic EXP_ERR_FULL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] tlp_i = '0;
  logic [2:0]   req_i = 3'd0;
  logic         ack_en_i = 1'b0;
  logic [11:0]  ack_seq_i = 12'd0;
  logic [255:0] tlp_o;
  logic [2:0]   req_o;
  logic [11:0]  seq_o;
  logic         sof_o, eof_o;
  logic [10:0]  retry_buffer_leftover_cnt_o;
  logic         outst_full_o;
  logic         err_o;

  dll_tx_seq_tracker dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .tlp_i                       (tlp_i),
    .req_i                       (req_i),
    .ack_en_i                    (ack_en_i),
    .ack_seq_i                   (ack_seq_i),
    .tlp_o                       (tlp_o),
    .req_o                       (req_o),
    .seq_o                       (seq_o),
    .sof_o                       (sof_o),
    .eof_o                       (eof_o),
    .retry_buffer_leftover_cnt_o (retry_buffer_leftover_cnt_o),
    .outst_full_o                (outst_full_o),
    .err_o                       (err_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;

  logic [255:0] m_tlp;
  logic [2:0]   m_req;
  int           m_seq, m_left, m_next, m_rem, m_ack_s;
  bit           m_sof, m_eof, m_err, m_in_data, m_ack_v;
  int           tbl_seq[$];
  int           tbl_units[$];
  logic [11:0]  exp_q[$];
  bit           rnd_ack = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tlp = '0; m_req = 3'd0; m_seq = 0; m_left = CAP; m_next = 0; m_rem = 0;
    m_ack_s = 0; m_sof = 0; m_eof = 0; m_err = 0; m_in_data = 0; m_ack_v = 0;
    tbl_seq.delete();
    tbl_units.delete();
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int  beats, dw, credit, debit;
    bit  full, hdr, dat;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hdr    = req_i inside {3'd1, 3'd3, 3'd5};
    dat    = req_i inside {3'd2, 3'd6};
    full   = (tbl_seq.size() == DEPTH);
    credit = 0;
    debit  = 0;
    if (m_ack_v && tbl_seq.size() > 0 && ((m_ack_s - tbl_seq[0]) & 4095) < 2048) begin
      credit = tbl_units[0];
      void'(tbl_seq.pop_front());
      void'(tbl_units.pop_front());
    end
    m_tlp = tlp_i;
    m_req = req_i;
    m_sof = 0;
    m_eof = 0;
    if (hdr) begin
      beats = 0;
      if (tlp_i[30]) begin
        dw    = (tlp_i[9:0] == 10'd0) ? 1024 : int'(tlp_i[9:0]);
        beats = (dw + 7) / 8;
      end
`ifdef DLL_TX_SEQ_CHECK_EN
      if (m_in_data || full || (beats + 1 > m_left)) m_err = 1;
`endif
      m_sof = 1;
      m_eof = (beats == 0);
      m_seq = m_next;
      exp_q.push_back(12'(m_next));
      m_next = (m_next + 1) % 4096;
      if (!full) begin
        tbl_seq.push_back(m_seq);
        tbl_units.push_back(beats + 1);
        debit = beats + 1;
      end
      m_in_data = (beats != 0);
      m_rem     = beats;
    end else if (dat) begin
      if (!m_in_data) begin
`ifdef DLL_TX_SEQ_CHECK_EN
        m_err = 1;
`endif
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          m_eof     = 1;
          m_in_data = 0;
        end
      end
    end
    m_left = m_left + credit - debit;
    if (m_left < 0)   m_left = 0;
    if (m_left > CAP) m_left = CAP;
    if (ack_en_i) begin
      m_ack_v = 1;
      m_ack_s = int'(ack_seq_i);
    end
  endtask

  task automatic compare_all();
    check("req_o", req_o, m_req);
    check("tlp_o", tlp_o, m_tlp);
    check("seq_o", seq_o, m_seq);
    check("sof_o", sof_o, m_sof);
    check("eof_o", eof_o, m_eof);
    check("leftover", retry_buffer_leftover_cnt_o, m_left);
    check("outst_full", outst_full_o, tbl_seq.size() == DEPTH);
    check("err_o", err_o, m_err);
    if (sof_o === 1'b1) begin
      if (exp_q.size() == 0) check("sof_unexpected", sof_o, 1'b0);
      else                   check("sof_seq", seq_o, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] code, input logic [255:0] data,
                       input logic aen, input logic [11:0] aseq);
    req_i     = code;
    tlp_i     = data;
    ack_en_i  = aen;
    ack_seq_i = aseq;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [255:0] hdr_word(input bit wd, input int len);
    logic [255:0] d;
    d       = rand256();
    d[30]   = wd;
    d[9:0]  = 10'(len);
    return d;
  endfunction

  function automatic logic [2:0] gap_code();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 3'd0 : (r == 1) ? 3'd4 : 3'd7;
  endfunction

  task automatic beat(input logic [2:0] code, input logic [255:0] data);
    logic        aen;
    logic [11:0] aseq;
    aen  = 1'b0;
    aseq = 12'd0;
    if (rnd_ack && $urandom_range(0, 5) == 0) begin
      aen  = 1'b1;
      aseq = 12'(m_next - 1 - int'($urandom_range(0, 3)));
    end
    drive(code, data, aen, aseq);
  endtask

  task automatic send_tlp(input logic [2:0] code, input bit wd, input int len, input int gap_max);
    int beats;
    beats = wd ? ((((len == 0) ? 1024 : len) + 7) / 8) : 0;
    beat(code, hdr_word(wd, len));
    for (int i = 0; i < beats; i++) begin
      repeat ($urandom_range(0, gap_max)) beat(gap_code(), rand256());
      beat((code == 3'd5) ? 3'd6 : 3'd2, rand256());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(3'd0, '0, 1'b0, 12'd0);
    drive(3'd0, '0, 1'b0, 12'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();

    // Reset state and a single zero-data NP header.
    do_reset();
    check("rst_leftover", retry_buffer_leftover_cnt_o, 11'd1024);
    check("rst_seq", seq_o, 12'd0);
    drive(3'd3, hdr_word(1'b0, 5), 1'b0, 12'd0);
    check("np_req", req_o, 3'd3);
    check("np_seq", seq_o, 12'd0);
    check("np_sof", sof_o, 1'b1);
    check("np_eof", eof_o, 1'b1);
    check("np_leftover", retry_buffer_leftover_cnt_o, 11'd1023);

    // Posted write of 16 DW with an IDLE between its two data beats.
    do_reset();
    drive(3'd1, hdr_word(1'b1, 16), 1'b0, 12'd0);
    check("pw_hdr_seq", seq_o, 12'd0);
    drive(3'd2, rand256(), 1'b0, 12'd0);
    check("pw_d1_eof", eof_o, 1'b0);
    check("pw_d1_seq", seq_o, 12'd0);
    drive(3'd0, '0, 1'b0, 12'd0);
    check("pw_gap_eof", eof_o, 1'b0);
    drive(3'd2, rand256(), 1'b0, 12'd0);
    check("pw_d2_eof", eof_o, 1'b1);
    check("pw_d2_seq", seq_o, 12'd0);
    check("pw_leftover", retry_buffer_leftover_cnt_o, 11'd1021);

    // Length 0 means 1024 DW: 128 data beats, 129 units.
    do_reset();
    send_tlp(3'd1, 1'b1, 0, 0);
    check("len0_eof", eof_o, 1'b1);
    check("len0_leftover", retry_buffer_leftover_cnt_o, 11'd895);

    // Reset in the middle of a TLP abandons it.
    do_reset();
    drive(3'd5, hdr_word(1'b1, 64), 1'b0, 12'd0);
    drive(3'd6, rand256(), 1'b0, 12'd0);
    do_reset();
    drive(3'd6, rand256(), 1'b0, 12'd0);
    check("mid_rst_eof", eof_o, 1'b0);

    // Same-cycle retire of a 5-unit entry and push of a 3-unit entry.
    do_reset();
    send_tlp(3'd1, 1'b1, 32, 0);
    drive(3'd0, '0, 1'b1, 12'd0);
    check("net_before", retry_buffer_leftover_cnt_o, 11'd1019);
    drive(3'd1, hdr_word(1'b1, 16), 1'b0, 12'd0);
    check("net_after", retry_buffer_leftover_cnt_o, 11'd1021);
    drive(3'd2, rand256(), 1'b0, 12'd0);
    drive(3'd2, rand256(), 1'b0, 12'd0);

    // 4097 zero-data headers, each acknowledged right away: sequence wraps.
    do_reset();
    for (int i = 0; i <= 4096; i++) begin
      drive(3'd3, hdr_word(1'b0, 0), 1'b0, 12'd0);
      if (i == 4095) check("wrap_seq_4095", seq_o, 12'd4095);
      if (i == 4096) check("wrap_seq_0", seq_o, 12'd0);
      drive(3'd0, '0, 1'b1, 12'(i));
    end
    drive(3'd0, '0, 1'b0, 12'd0);
    drive(3'd0, '0, 1'b0, 12'd0);
    check("wrap_leftover", retry_buffer_leftover_cnt_o, 11'd1024);

    // Fill the outstanding table, then one more header.
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(3'd3, hdr_word(1'b0, 0), 1'b0, 12'd0);
    check("fill_full", outst_full_o, 1'b1);
    drive(3'd3, hdr_word(1'b0, 0), 1'b0, 12'd0);
    check("over_full", outst_full_o, 1'b1);
    check("over_req", req_o, 3'd3);
    check("over_leftover", retry_buffer_leftover_cnt_o, 11'd992);
    check("over_err", err_o, EXP_ERR_FULL);
    drive(3'd0, '0, 1'b1, 12'd32);
    for (int i = 0; i < DEPTH + 2; i++) drive(3'd0, '0, 1'b0, 12'd0);
    check("drain_full", outst_full_o, 1'b0);
    check("drain_leftover", retry_buffer_leftover_cnt_o, 11'd1024);

    // Randomized well-formed traffic with random gaps and Acks.
    do_reset();
    rnd_ack = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [2:0] code;
      int         r;
      r    = $urandom_range(0, 2);
      code = (r == 0) ? 3'd1 : (r == 1) ? 3'd3 : 3'd5;
      send_tlp(code, ($urandom_range(0, 3) != 0), $urandom_range(1, 200), 2);
      repeat ($urandom_range(0, 2)) beat(gap_code(), rand256());
    end
    rnd_ack = 1'b0;
    drive(3'd0, '0, 1'b1, 12'(m_next - 1));
    for (int i = 0; i < DEPTH + 2; i++) drive(3'd0, '0, 1'b0, 12'd0);
    check("rand_leftover", retry_buffer_leftover_cnt_o, 11'd1024);
    check("exp_q_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
